mips_multi_ctrl_hs: RTL and testbench
=====================================

// Module: mips_multi_ctrl_hs
// PURPOSE
//  Next-generation multicycle MIPS controller: main FSM plus ALU decoder with an
//  extended ISA (BNE, ANDI/ORI/XORI/SLTI, LBU, JAL) and a variable-latency memory
//  handshake. Memory-access states hold until mem_ready. A wait-cycle watchdog and
//  an illegal-opcode check send the FSM to a sticky TRAP state.
//  Sits between the instruction register (op/funct) and the existing datapath.
// PARAMETERS
//  MEM_TIMEOUT   16  max consecutive wait cycles in one memory state; 0 disables watchdog
//  TRAP_ILLEGAL  1   1: undefined opcode -> TRAP; 0: undefined opcode -> FETCH (treated as NOP)
//  TO_W          derived localparam, $clog2(MEM_TIMEOUT+1), min 1; not user-set
// PORTS
//  clk        in   1  clock
//  reset      in   1  reset, asynchronous, active-high
//  op         in   6  instr[31:26]
//  funct      in   6  instr[5:0]
//  zero       in   1  ALU zero flag
//  mem_ready  in   1  memory done this cycle (read data valid / write accepted)
//  memread    out  1  memory read request
//  memwrite   out  1  memory write request
//  pcen       out  1  PC register enable
//  irwrite    out  1  instruction register enable
//  regwrite   out  1  register file write enable
//  alusrca    out  1  0 = PC, 1 = A
//  iord       out  1  0 = PC address, 1 = ALUOut address
//  regdst     out  2  00 = rt, 01 = rd, 10 = $31
//  memtoreg   out  2  00 = ALUOut, 01 = data, 10 = PC
//  alusrcb    out  3  000 = B, 001 = 4, 010 = signimm, 011 = signimm<<2, 100 = zeroimm
//  pcsrc      out  2  00 = ALUResult, 01 = ALUOut, 10 = jump target
//  alucontrol out  3  010 add, 110 sub, 000 and, 001 or, 011 xor, 111 slt
//  lbu        out  1  byte-load zero-extend select in the MEMWB state
//  instret    out  1  1-cycle pulse on the last cycle of each retired instruction
//  trap       out  1  sticky; high while the FSM is in TRAP
// BEHAVIOUR
//  - Reset (async): state = FETCH, wait counter = 0, trap = 0. While reset is high,
//    every output is 0 except alusrcb = 001.
//  - Outputs are combinational from state, op, funct, zero and mem_ready (Moore-style plus ready gating).
//  - pcen = pcwrite | (beq & zero) | (bne & ~zero).
//  - FETCH: memread = 1, iord = 0, alusrca = 0, alusrcb = 001, aluop = add.
//    irwrite and pcwrite assert only in the cycle mem_ready = 1; the FSM then moves to DECODE.
//    Otherwise it stays in FETCH.
//  - DECODE: alusrcb = 011, add (branch target into ALUOut). Next state by op:
//    LW/SW/LBU -> MEMADR; RTYPE -> EXECUTE; BEQ/BNE -> BRANCH;
//    ADDI/SLTI/ANDI/ORI/XORI -> IMMEX; J -> JUMP; JAL -> JAL.
//    Any other op -> TRAP (TRAP_ILLEGAL = 1) or FETCH (TRAP_ILLEGAL = 0).
//  - MEMADR: alusrca = 1, alusrcb = 010, add. Then LW/LBU -> MEMRD, SW -> MEMWR.
//  - MEMRD: memread = 1, iord = 1. Holds until mem_ready, then -> MEMWB.
//  - MEMWB: regwrite = 1, memtoreg = 01, regdst = 00, lbu = (op == LBU). Then -> FETCH.
//  - MEMWR: memwrite = 1, iord = 1. Holds until mem_ready, then -> FETCH.
//    memwrite stays asserted through the wait.
//  - EXECUTE: alusrca = 1, alusrcb = 000, ALU op from funct:
//    100000 add, 100010 sub, 100100 and, 100101 or, 100110 xor, 101010 slt.
//    Any other funct -> TRAP (TRAP_ILLEGAL = 1). Otherwise -> ALUWB.
//  - ALUWB: regwrite = 1, regdst = 01, memtoreg = 00. Then -> FETCH.
//  - BRANCH: alusrca = 1, alusrcb = 000, sub, pcsrc = 01. Then -> FETCH.
//  - IMMEX: alusrca = 1. ADDI and SLTI use alusrcb = 010; ANDI, ORI and XORI use 100.
//    ALU op: add / slt / and / or / xor respectively. Then -> IMMWB.
//  - IMMWB: regwrite = 1, regdst = 00, memtoreg = 00. Then -> FETCH.
//  - JUMP: pcwrite = 1, pcsrc = 10. Then -> FETCH.
//  - JAL: one cycle. regwrite = 1, regdst = 10, memtoreg = 10 (PC already holds PC+4),
//    pcwrite = 1, pcsrc = 10. Then -> FETCH.
//  - instret is 1 in the final state of each instruction (MEMWB; MEMWR with mem_ready;
//    ALUWB; BRANCH; IMMWB; JUMP; JAL). It is never 1 in TRAP or on an illegal-op exit.
//  - Watchdog counter:
//    - Increments each cycle spent in FETCH, MEMRD or MEMWR with mem_ready = 0.
//    - Clears on any state change.
//    - With MEM_TIMEOUT > 0, when it reaches MEM_TIMEOUT while still waiting: -> TRAP.
//    - Saturates; never wraps.
//    - mem_ready in the same cycle as the limit: the ready wins and the FSM advances normally.
//  - TRAP: all enables 0, trap = 1. Exit only through reset.
//  - Reset mid-instruction: the partial instruction is abandoned; no write enable is
//    asserted in the cycle after release except per FETCH rules.
// STRUCTURE
//  - Package mips_multi_pkg: opcode and funct localparams, state enum (5 bits, TRAP = 5'h1F),
//    alusrcb / pcsrc / regdst / memtoreg / alucontrol encodings.
//  - Sub-module mips_aludec_x: combinational aluop(3) + funct -> alucontrol(3) plus an
//    illegal-funct flag. It has no state.
//  - Top level contains: state register, watchdog counter, next-state logic, output decode.
// TESTING
//  - LW with mem_ready delayed 3 cycles in FETCH and MEMRD
//    -> irwrite/pcen pulse once each; 5+3+3 cycles total; one instret.
//  - BNE with zero = 0 -> pcen = 1, pcsrc = 01 in BRANCH.
//    BNE with zero = 1 -> pcen = 0.
//  - ORI 001101 -> IMMEX shows alusrcb = 100, alucontrol = 001.
//    IMMWB shows regwrite = 1, regdst = 00.
//  - JAL 000011 -> a single JAL cycle with regdst = 10, memtoreg = 10, pcen = 1,
//    pcsrc = 10, instret = 1.
//  - MEM_TIMEOUT = 4, mem_ready held 0 in MEMWR
//    -> TRAP after 4 wait cycles; trap stays 1 and memwrite = 0 until reset.
//  - op = 111111 with TRAP_ILLEGAL = 1 -> DECODE -> TRAP, no instret.
//    Async reset mid-EXECUTE -> FETCH next edge, trap = 0.

Source files
------------

// File: rtl/mips_multi_ctrl_hs_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, functs,
// FSM states, ALU operation classes and datapath mux select codes.
package mips_multi_pkg;

  // Opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_LBU   = 6'b100100;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type funct codes (instr[5:0])
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // Main FSM states; TRAP sits at the top of the code space
  typedef enum logic [4:0] {
    S_FETCH   = 5'd0,
    S_DECODE  = 5'd1,
    S_MEMADR  = 5'd2,
    S_MEMRD   = 5'd3,
    S_MEMWB   = 5'd4,
    S_MEMWR   = 5'd5,
    S_EXECUTE = 5'd6,
    S_ALUWB   = 5'd7,
    S_BRANCH  = 5'd8,
    S_IMMEX   = 5'd9,
    S_IMMWB   = 5'd10,
    S_JUMP    = 5'd11,
    S_JAL     = 5'd12,
    S_TRAP    = 5'h1F
  } state_e;

  // Operation class handed from the FSM to the ALU decoder
  typedef enum logic [2:0] {
    ALUOP_ADD   = 3'd0,
    ALUOP_SUB   = 3'd1,
    ALUOP_FUNCT = 3'd2,
    ALUOP_SLT   = 3'd3,
    ALUOP_AND   = 3'd4,
    ALUOP_OR    = 3'd5,
    ALUOP_XOR   = 3'd6
  } aluop_e;

  // ALU B-operand select
  localparam logic [2:0] SRCB_B       = 3'b000;
  localparam logic [2:0] SRCB_FOUR    = 3'b001;
  localparam logic [2:0] SRCB_SIGNIMM = 3'b010;
  localparam logic [2:0] SRCB_SIGNSH  = 3'b011;
  localparam logic [2:0] SRCB_ZEROIMM = 3'b100;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Register destination select
  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;

  // Register write-data select
  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_DATA   = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  // ALU control codes seen by the datapath
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/mips_multi_ctrl_hs_if.sv
// Controller <-> datapath/memory bundle. The controller side (master) reads
// the instruction fields, ALU flag and memory ready, and drives all enables.
interface mips_multi_ctrl_hs_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       memread;
  logic       memwrite;
  logic       pcen;
  logic       irwrite;
  logic       regwrite;
  logic       alusrca;
  logic       iord;
  logic [1:0] regdst;
  logic [1:0] memtoreg;
  logic [2:0] alusrcb;
  logic [1:0] pcsrc;
  logic [2:0] alucontrol;
  logic       lbu;
  logic       instret;
  logic       trap;

  modport master (
    input  op, funct, zero, mem_ready,
    output memread, memwrite, pcen, irwrite, regwrite, alusrca, iord,
           regdst, memtoreg, alusrcb, pcsrc, alucontrol, lbu, instret, trap
  );

  modport slave (
    output op, funct, zero, mem_ready,
    input  memread, memwrite, pcen, irwrite, regwrite, alusrca, iord,
           regdst, memtoreg, alusrcb, pcsrc, alucontrol, lbu, instret, trap
  );
endinterface

// File: rtl/mips_multi_ctrl_hs_aludec.sv
// Stateless ALU decoder: maps the FSM's operation class (and funct for
// R-type) to the datapath ALU control code, flagging unknown functs.
module mips_aludec_x
  import mips_multi_pkg::*;
(
  input  aluop_e     aluop_i,
  input  logic [5:0] funct_i,
  output logic [2:0] alucontrol_o,
  output logic       illegal_funct_o
);

  // Decode operation class, falling through to funct for R-type
  always_comb begin
    alucontrol_o    = ALU_ADD;
    illegal_funct_o = 1'b0;
    case (aluop_i)
      ALUOP_ADD: alucontrol_o = ALU_ADD;
      ALUOP_SUB: alucontrol_o = ALU_SUB;
      ALUOP_SLT: alucontrol_o = ALU_SLT;
      ALUOP_AND: alucontrol_o = ALU_AND;
      ALUOP_OR:  alucontrol_o = ALU_OR;
      ALUOP_XOR: alucontrol_o = ALU_XOR;
      ALUOP_FUNCT: begin
        case (funct_i)
          FN_ADD:  alucontrol_o = ALU_ADD;
          FN_SUB:  alucontrol_o = ALU_SUB;
          FN_AND:  alucontrol_o = ALU_AND;
          FN_OR:   alucontrol_o = ALU_OR;
          FN_XOR:  alucontrol_o = ALU_XOR;
          FN_SLT:  alucontrol_o = ALU_SLT;
          default: illegal_funct_o = 1'b1;
        endcase
      end
      default: alucontrol_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_multi_ctrl_hs.sv
// Multicycle MIPS main controller with variable-latency memory handshake,
// a per-state wait watchdog and a sticky TRAP state left only by reset.
module mips_multi_ctrl_hs
  import mips_multi_pkg::*;
#(
  parameter int MEM_TIMEOUT  = 16,
  parameter bit TRAP_ILLEGAL = 1'b1
) (
  input logic                  clk,
  input logic                  reset,
  mips_multi_ctrl_hs_if.master bus
);

  localparam int              TO_W   = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [TO_W-1:0] TO_LIM = TO_W'(MEM_TIMEOUT);

  state_e          state_q, state_d;
  logic [TO_W-1:0] wait_q, wait_d;
  aluop_e          aluop;
  logic [2:0]      alucontrol;
  logic            illegal_funct;
  logic            waiting, wd_expire;
  logic            pcwrite, branch_eq, branch_ne;
  logic            memread, memwrite, irwrite, regwrite, alusrca, iord;
  logic            lbu, instret, trap;
  logic [1:0]      regdst, memtoreg, pcsrc;
  logic [2:0]      alusrcb;

  // A memory-facing state with no ready this cycle is a wait cycle
  assign waiting   = (state_q inside {S_FETCH, S_MEMRD, S_MEMWR}) && !bus.mem_ready;
  // Fires on the wait cycle that would bring the count up to the limit
  assign wd_expire = (MEM_TIMEOUT > 0) && waiting && (wait_q >= TO_LIM - 1'b1);

  mips_aludec_x u_aludec (
    .aluop_i         (aluop),
    .funct_i         (bus.funct),
    .alucontrol_o    (alucontrol),
    .illegal_funct_o (illegal_funct)
  );

  // State and watchdog registers with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Watchdog: clear on state change, saturating count of wait cycles
  always_comb begin
    wait_d = wait_q;
    if (state_d != state_q) begin
      wait_d = '0;
    end else if (waiting && (wait_q != '1)) begin
      wait_d = wait_q + 1'b1;
    end
  end

  // Next-state logic; ready always beats the watchdog in the same cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (bus.mem_ready)  state_d = S_DECODE;
        else if (wd_expire) state_d = S_TRAP;
      end
      S_DECODE: begin
        case (bus.op)
          OP_LW, OP_LBU, OP_SW:                       state_d = S_MEMADR;
          OP_RTYPE:                                   state_d = S_EXECUTE;
          OP_BEQ, OP_BNE:                             state_d = S_BRANCH;
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: state_d = S_IMMEX;
          OP_J:                                       state_d = S_JUMP;
          OP_JAL:                                     state_d = S_JAL;
          default: state_d = TRAP_ILLEGAL ? S_TRAP : S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (bus.op == OP_LW || bus.op == OP_LBU) state_d = S_MEMRD;
        else if (bus.op == OP_SW)                state_d = S_MEMWR;
        else                                     state_d = S_FETCH;
      end
      S_MEMRD: begin
        if (bus.mem_ready)  state_d = S_MEMWB;
        else if (wd_expire) state_d = S_TRAP;
      end
      S_MEMWR: begin
        if (bus.mem_ready)  state_d = S_FETCH;
        else if (wd_expire) state_d = S_TRAP;
      end
      S_EXECUTE: begin
        if (illegal_funct) state_d = TRAP_ILLEGAL ? S_TRAP : S_FETCH;
        else               state_d = S_ALUWB;
      end
      S_MEMWB, S_ALUWB, S_BRANCH, S_IMMWB, S_JUMP, S_JAL: state_d = S_FETCH;
      S_IMMEX: state_d = S_IMMWB;
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase
  end

  // ALU operation class requested in each state
  always_comb begin
    aluop = ALUOP_ADD;
    case (state_q)
      S_EXECUTE: aluop = ALUOP_FUNCT;
      S_BRANCH:  aluop = ALUOP_SUB;
      S_IMMEX: begin
        case (bus.op)
          OP_SLTI: aluop = ALUOP_SLT;
          OP_ANDI: aluop = ALUOP_AND;
          OP_ORI:  aluop = ALUOP_OR;
          OP_XORI: aluop = ALUOP_XOR;
          default: aluop = ALUOP_ADD;
        endcase
      end
      default: aluop = ALUOP_ADD;
    endcase
  end

  // Per-state datapath controls, ready-gated where memory is involved
  always_comb begin
    memread   = 1'b0;
    memwrite  = 1'b0;
    irwrite   = 1'b0;
    regwrite  = 1'b0;
    alusrca   = 1'b0;
    iord      = 1'b0;
    regdst    = REGDST_RT;
    memtoreg  = M2R_ALUOUT;
    alusrcb   = SRCB_B;
    pcsrc     = PCSRC_ALU;
    pcwrite   = 1'b0;
    branch_eq = 1'b0;
    branch_ne = 1'b0;
    lbu       = 1'b0;
    instret   = 1'b0;
    trap      = 1'b0;
    case (state_q)
      S_FETCH: begin
        memread = 1'b1;
        alusrcb = SRCB_FOUR;
        irwrite = bus.mem_ready;
        pcwrite = bus.mem_ready;
      end
      S_DECODE: alusrcb = SRCB_SIGNSH;
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = SRCB_SIGNIMM;
      end
      S_MEMRD: begin
        memread = 1'b1;
        iord    = 1'b1;
      end
      S_MEMWB: begin
        regwrite = 1'b1;
        memtoreg = M2R_DATA;
        lbu      = (bus.op == OP_LBU);
        instret  = 1'b1;
      end
      S_MEMWR: begin
        memwrite = 1'b1;
        iord     = 1'b1;
        instret  = bus.mem_ready;
      end
      S_EXECUTE: alusrca = 1'b1;
      S_ALUWB: begin
        regwrite = 1'b1;
        regdst   = REGDST_RD;
        instret  = 1'b1;
      end
      S_BRANCH: begin
        alusrca   = 1'b1;
        pcsrc     = PCSRC_ALUOUT;
        branch_eq = (bus.op == OP_BEQ);
        branch_ne = (bus.op == OP_BNE);
        instret   = 1'b1;
      end
      S_IMMEX: begin
        alusrca = 1'b1;
        alusrcb = (bus.op == OP_ADDI || bus.op == OP_SLTI) ? SRCB_SIGNIMM : SRCB_ZEROIMM;
      end
      S_IMMWB: begin
        regwrite = 1'b1;
        instret  = 1'b1;
      end
      S_JUMP: begin
        pcwrite = 1'b1;
        pcsrc   = PCSRC_JUMP;
        instret = 1'b1;
      end
      S_JAL: begin
        regwrite = 1'b1;
        regdst   = REGDST_RA;
        memtoreg = M2R_PC;
        pcwrite  = 1'b1;
        pcsrc    = PCSRC_JUMP;
        instret  = 1'b1;
      end
      S_TRAP:  trap = 1'b1;
      default: trap = 1'b0;
    endcase
    // Hold the datapath quiet while reset is asserted
    if (reset) begin
      memread   = 1'b0;
      irwrite   = 1'b0;
      pcwrite   = 1'b0;
      alusrcb   = SRCB_FOUR;
      branch_eq = 1'b0;
      branch_ne = 1'b0;
      lbu       = 1'b0;
      trap      = 1'b0;
    end
  end

  assign bus.memread    = memread;
  assign bus.memwrite   = memwrite;
  assign bus.pcen       = pcwrite | (branch_eq & bus.zero) | (branch_ne & ~bus.zero);
  assign bus.irwrite    = irwrite;
  assign bus.regwrite   = regwrite;
  assign bus.alusrca    = alusrca;
  assign bus.iord       = iord;
  assign bus.regdst     = regdst;
  assign bus.memtoreg   = memtoreg;
  assign bus.alusrcb    = alusrcb;
  assign bus.pcsrc      = pcsrc;
  assign bus.alucontrol = reset ? 3'b000 : alucontrol;
  assign bus.lbu        = lbu;
  assign bus.instret    = instret;
  assign bus.trap       = trap;

endmodule

// File: tb/tb_mips_multi_ctrl_hs.sv
// Randomized directed bench for mips_multi_ctrl_hs. Each instruction is
// expanded into its expected per-cycle output trace from the ISA rules
// (fetch waits, phase list per instruction class, watchdog limit) and every
// cycle's outputs are compared against that trace under a care mask.
module tb_mips_multi_ctrl_hs;

  localparam int TIMEOUT = 4;

  localparam logic [5:0] OP_RTYPE = 6'b000000, OP_J    = 6'b000010, OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100, OP_BNE  = 6'b000101, OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010, OP_ANDI = 6'b001100, OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110, OP_LW   = 6'b100011, OP_LBU  = 6'b100100;
  localparam logic [5:0] OP_SW    = 6'b101011;

  typedef struct packed {
    logic       memread, memwrite, pcen, irwrite, regwrite, alusrca, iord;
    logic [1:0] regdst, memtoreg;
    logic [2:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] alucontrol;
    logic       lbu, instret, trap;
  } outs_t;

  logic  clk;
  logic  reset;
  outs_t obs;
  int    checks = 0;
  int    errors = 0;

  mips_multi_ctrl_hs_if bus ();

  mips_multi_ctrl_hs #(
    .MEM_TIMEOUT  (TIMEOUT),
    .TRAP_ILLEGAL (1'b1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign obs = {bus.memread, bus.memwrite, bus.pcen, bus.irwrite, bus.regwrite,
                bus.alusrca, bus.iord, bus.regdst, bus.memtoreg, bus.alusrcb,
                bus.pcsrc, bus.alucontrol, bus.lbu, bus.instret, bus.trap};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running required=finished");
    $fatal(1, "simulation time limit");
  end

  function automatic logic rnd();
    return 1'($urandom);
  endfunction

  // Enables and status are always checked
  function automatic outs_t en_care();
    outs_t c = '0;
    c.memread = 1'b1; c.memwrite = 1'b1; c.pcen = 1'b1; c.irwrite = 1'b1;
    c.regwrite = 1'b1; c.lbu = 1'b1; c.instret = 1'b1; c.trap = 1'b1;
    return c;
  endfunction

  // Enables plus the ALU operand/operation selects
  function automatic outs_t alu_care();
    outs_t c = en_care();
    c.alusrca = 1'b1; c.alusrcb = '1; c.alucontrol = '1;
    return c;
  endfunction

  function automatic bit fn_ctrl(input logic [5:0] f, output logic [2:0] ac);
    ac = 3'b010;
    case (f)
      6'b100000: ac = 3'b010;
      6'b100010: ac = 3'b110;
      6'b100100: ac = 3'b000;
      6'b100101: ac = 3'b001;
      6'b100110: ac = 3'b011;
      6'b101010: ac = 3'b111;
      default:   return 1'b0;
    endcase
    return 1'b1;
  endfunction

  // {alusrcb, alucontrol} for immediate ALU instructions
  function automatic logic [5:0] imm_ctrl(input logic [5:0] o);
    case (o)
      OP_SLTI: return {3'b010, 3'b111};
      OP_ANDI: return {3'b100, 3'b000};
      OP_ORI:  return {3'b100, 3'b001};
      OP_XORI: return {3'b100, 3'b011};
      default: return {3'b010, 3'b010};
    endcase
  endfunction

  function automatic logic [5:0] pick_op(input int unsigned i);
    case (i)
      0: return OP_RTYPE; 1: return OP_J;    2: return OP_JAL;  3: return OP_BEQ;
      4: return OP_BNE;   5: return OP_ADDI; 6: return OP_SLTI; 7: return OP_ANDI;
      8: return OP_ORI;   9: return OP_XORI; 10: return OP_LW;  11: return OP_LBU;
      default: return OP_SW;
    endcase
  endfunction

  function automatic logic [5:0] pick_fn(input int unsigned i);
    case (i)
      0: return 6'b100000; 1: return 6'b100010; 2: return 6'b100100;
      3: return 6'b100101; 4: return 6'b100110; default: return 6'b101010;
    endcase
  endfunction

  task automatic check(input string tag, input outs_t e, input outs_t c);
    logic [21:0] o_m, e_m;
    o_m = obs & c;
    e_m = e & c;
    checks++;
    assert (o_m === e_m) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h care=%h", tag, o_m, e_m, c);
    end
  endtask

  // One clock cycle: drive ready, compare mid-cycle, advance past next edge
  task automatic cyc(input string tag, input outs_t e, input outs_t c, input logic rdy);
    bus.mem_ready = rdy;
    #1;
    check(tag, e, c);
    @(posedge clk);
    #1;
  endtask

  // Memory-facing phase: d wait cycles then ready, unless the watchdog trips first
  task automatic wait_phase(input string tag, input outs_t ew, input outs_t ed,
                            input outs_t c, input int d, output bit fired);
    fired = 1'b0;
    for (int i = 0; i <= d; i++) begin
      if (i == TIMEOUT) begin
        fired = 1'b1;
        break;
      end
      if (i == d) cyc(tag, ed, c, 1'b1);
      else        cyc(tag, ew, c, 1'b0);
    end
  endtask

  task automatic do_reset(input string tag);
    outs_t e, c;
    e = '0;
    e.alusrcb = 3'b001;
    c = '1;
    reset = 1'b1;
    #1;
    check({tag, "_rst_assert"}, e, c);
    @(posedge clk);
    #1;
    bus.mem_ready = 1'b1;
    #1;
    check({tag, "_rst_hold"}, e, c);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Sticky trap: nothing enabled regardless of inputs, then reset
  task automatic trap_then_reset(input string tag);
    outs_t e, c;
    e = '0;
    e.trap = 1'b1;
    c = en_care();
    for (int i = 0; i < 3; i++) begin
      bus.zero = rnd();
      cyc({tag, "_trap"}, e, c, rnd());
    end
    do_reset(tag);
  endtask

  task automatic fetch_decode(input logic [5:0] o, input logic [5:0] f, input logic zf,
                              input int df, output bit fired);
    outs_t e, ed, c;
    bus.op = o;
    bus.funct = f;
    bus.zero = zf;
    e = '0;
    e.memread = 1'b1; e.alusrcb = 3'b001; e.alucontrol = 3'b010;
    c = alu_care();
    c.iord = 1'b1;
    ed = e;
    ed.irwrite = 1'b1; ed.pcen = 1'b1;
    wait_phase("fetch", e, ed, c, df, fired);
    if (!fired) begin
      e = '0;
      e.alusrcb = 3'b011; e.alucontrol = 3'b010;
      cyc("decode", e, alu_care(), rnd());
    end
  endtask

  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic zf,
                           input int df, input int dm);
    outs_t e, c, ew, ed;
    bit fired;
    logic [2:0] ac;
    logic [5:0] ic;
    $display("instr op=%b funct=%b zero=%b fetch_wait=%0d mem_wait=%0d", o, f, zf, df, dm);
    fetch_decode(o, f, zf, df, fired);
    if (fired) begin
      trap_then_reset("fetch_timeout");
      return;
    end
    case (o)
      OP_LW, OP_LBU, OP_SW: begin
        e = '0;
        e.alusrca = 1'b1; e.alusrcb = 3'b010; e.alucontrol = 3'b010;
        cyc("memadr", e, alu_care(), rnd());
        ew = '0;
        ew.iord = 1'b1;
        c = en_care();
        c.iord = 1'b1;
        if (o == OP_SW) begin
          ew.memwrite = 1'b1;
          ed = ew;
          ed.instret = 1'b1;
          wait_phase("memwr", ew, ed, c, dm, fired);
        end else begin
          ew.memread = 1'b1;
          wait_phase("memrd", ew, ew, c, dm, fired);
          if (!fired) begin
            e = '0;
            e.regwrite = 1'b1; e.memtoreg = 2'b01; e.lbu = (o == OP_LBU); e.instret = 1'b1;
            c = en_care();
            c.regdst = '1; c.memtoreg = '1;
            cyc("memwb", e, c, rnd());
          end
        end
        if (fired) trap_then_reset("mem_timeout");
      end
      OP_RTYPE: begin
        e = '0;
        e.alusrca = 1'b1;
        if (fn_ctrl(f, ac)) begin
          e.alucontrol = ac;
          cyc("execute", e, alu_care(), rnd());
          e = '0;
          e.regwrite = 1'b1; e.regdst = 2'b01; e.instret = 1'b1;
          c = en_care();
          c.regdst = '1; c.memtoreg = '1;
          cyc("aluwb", e, c, rnd());
        end else begin
          cyc("execute_illegal", e, en_care(), rnd());
          trap_then_reset("illegal_funct");
        end
      end
      OP_BEQ, OP_BNE: begin
        e = '0;
        e.alusrca = 1'b1; e.alucontrol = 3'b110; e.pcsrc = 2'b01; e.instret = 1'b1;
        e.pcen = (o == OP_BEQ) ? zf : ~zf;
        c = alu_care();
        c.pcsrc = '1;
        cyc("branch", e, c, rnd());
      end
      OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: begin
        ic = imm_ctrl(o);
        e = '0;
        e.alusrca = 1'b1; e.alusrcb = ic[5:3]; e.alucontrol = ic[2:0];
        cyc("immex", e, alu_care(), rnd());
        e = '0;
        e.regwrite = 1'b1; e.instret = 1'b1;
        c = en_care();
        c.regdst = '1; c.memtoreg = '1;
        cyc("immwb", e, c, rnd());
      end
      OP_J: begin
        e = '0;
        e.pcen = 1'b1; e.pcsrc = 2'b10; e.instret = 1'b1;
        c = en_care();
        c.pcsrc = '1;
        cyc("jump", e, c, rnd());
      end
      OP_JAL: begin
        e = '0;
        e.regwrite = 1'b1; e.regdst = 2'b10; e.memtoreg = 2'b10;
        e.pcen = 1'b1; e.pcsrc = 2'b10; e.instret = 1'b1;
        c = en_care();
        c.regdst = '1; c.memtoreg = '1; c.pcsrc = '1;
        cyc("jal", e, c, rnd());
      end
      default: trap_then_reset("illegal_op");
    endcase
  endtask

  initial begin
    outs_t e;
    bit    fired;
    reset         = 1'b1;
    bus.op        = 6'b000000;
    bus.funct     = 6'b000000;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b0;
    @(posedge clk);
    #1;
    do_reset("init");

    // Directed: slow fetch and slow load (4+1+1+4+1 cycles)
    run_instr(OP_LW, 6'b000000, 1'b0, 3, 3);
    run_instr(OP_LBU, 6'b000000, 1'b1, 0, 1);
    run_instr(OP_BNE, 6'b000000, 1'b0, 0, 0);
    run_instr(OP_BNE, 6'b000000, 1'b1, 1, 0);
    run_instr(OP_BEQ, 6'b000000, 1'b1, 0, 0);
    run_instr(OP_ORI, 6'b000000, 1'b0, 2, 0);
    run_instr(OP_JAL, 6'b000000, 1'b0, 0, 0);
    run_instr(OP_SW, 6'b000000, 1'b0, 0, 3);
    // Store that never completes: watchdog trap after 4 wait cycles
    run_instr(OP_SW, 6'b000000, 1'b0, 0, 10);
    // Undefined opcode and undefined funct
    run_instr(6'b111111, 6'b000000, 1'b0, 0, 0);
    run_instr(OP_RTYPE, 6'b000000, 1'b0, 0, 0);
    // Fetch that never completes
    run_instr(OP_J, 6'b000000, 1'b0, 6, 0);

    // Reset in the middle of EXECUTE, then a normal instruction
    $display("instr op=%b funct=%b reset during execute", OP_RTYPE, 6'b100000);
    fetch_decode(OP_RTYPE, 6'b100000, 1'b0, 1, fired);
    e = '0;
    e.alusrca = 1'b1; e.alucontrol = 3'b010;
    bus.mem_ready = 1'b0;
    #1;
    check("execute_pre_reset", e, alu_care());
    do_reset("mid_execute");
    run_instr(OP_ADDI, 6'b000000, 1'b0, 0, 0);

    // Randomized instruction stream, occasionally stalling memory into a trap
    for (int n = 0; n < 60; n++) begin
      run_instr(pick_op($urandom_range(0, 12)), pick_fn($urandom_range(0, 5)),
                rnd(), int'($urandom_range(0, 3)), int'($urandom_range(0, 4)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
